// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store unit
//
// Purpose:
//   Shares one req/gnt memory port between the fetch path (port 0) and the
//   load/store unit (port 1). A winning request is latched in IDLE, presented
//   on the memory bus in REQ until accepted, and its response is routed back
//   to the owner in RESP. At most one transaction is outstanding.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, a tie goes to the port that did not own
//                        the previous transaction; otherwise the LSU wins ties.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req_i, if_addr_i        fetch request and address
//   if_gnt_o, if_rvalid_o      fetch accepted / fetch data valid
//   if_rdata_o                 fetch data (mirrors mem_rdata_i)
//   lsu_req_i, lsu_addr_i      data request and address
//   lsu_we_i, lsu_be_i         store enable, byte enables
//   lsu_wdata_i                store data
//   lsu_gnt_o, lsu_rvalid_o    data accepted / load data valid or store done
//   lsu_rdata_o                load data (mirrors mem_rdata_i)
//   mem_req_o, mem_gnt_i       memory request handshake
//   mem_addr_o, mem_we_o       latched address, write enable
//   mem_be_o, mem_wdata_o      latched byte enables, write data
//   mem_rvalid_i, mem_rdata_i  memory response
//   busy_o                     transaction in flight

module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  lsu_req_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  owner_lsu;  // 1 = current transaction belongs to the LSU
  logic                  latch;      // capture the winning request this cycle
  logic                  pick_lsu;   // arbitration result, valid when any request is up
  logic                  tie_lsu;    // who wins when both ports request
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  // Owner of the most recently launched transaction; starts as LSU so the
  // first tie after reset goes to fetch.
  logic last_owner_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_lsu <= 1'b1;
    end else if (latch) begin
      last_owner_lsu <= pick_lsu;
    end
  end

  assign tie_lsu = ~last_owner_lsu;
`else
  assign tie_lsu = 1'b1;
`endif

  assign pick_lsu = lsu_req_i & (~if_req_i | tie_lsu);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    latch        = 1'b0;
    mem_req_o    = 1'b0;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    case (state)
      IDLE: begin
        if (if_req_i || lsu_req_i) begin
          latch      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          if_gnt_o   = ~owner_lsu;
          lsu_gnt_o  = owner_lsu;
          state_next = RESP;
        end
      end
      RESP: begin
        // Responses are only honoured here; anything arriving in IDLE/REQ is dropped.
        if (mem_rvalid_i) begin
          if_rvalid_o  = ~owner_lsu;
          lsu_rvalid_o = owner_lsu;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request fields are held from the arbitration cycle until the next win,
  // so requesters may drop their inputs once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsu <= 1'b1;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= '0;
    end else if (latch) begin
      owner_lsu <= pick_lsu;
      if (pick_lsu) begin
        addr_q  <= lsu_addr_i;
        we_q    <= lsu_we_i;
        be_q    <= lsu_be_i;
        wdata_q <= lsu_wdata_i;
      end else begin
        addr_q  <= if_addr_i;
        we_q    <= 1'b0;
        be_q    <= 4'hF;
        wdata_q <= '0;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter

module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          lsu_req_i;
  logic [AW-1:0] lsu_addr_i;
  logic          lsu_we_i;
  logic [3:0]    lsu_be_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_gnt_o;
  logic          lsu_rvalid_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending requests per port, plus the previous owner for ties.
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  bit          m_last_lsu = 1'b1;
  bit          p_if, p_lsu;
  logic [31:0] if_a, l_a, l_d;
  bit          l_w;
  logic [3:0]  l_b;
  int          n_if_won, n_lsu_won;

  task automatic new_if();
    p_if = 1'b1;
    if_a = $urandom;
  endtask

  task automatic new_lsu();
    p_lsu = 1'b1;
    l_a   = $urandom;
    l_w   = 1'($urandom_range(0, 1));
    l_b   = 4'($urandom_range(0, 15));
    l_d   = $urandom;
  endtask

  task automatic apply_reqs();
    if_req_i    = p_if;
    if_addr_i   = if_a;
    lsu_req_i   = p_lsu;
    lsu_addr_i  = l_a;
    lsu_we_i    = l_w;
    lsu_be_i    = l_b;
    lsu_wdata_i = l_d;
  endtask

  function automatic bit model_pick_lsu();
    if (p_if && p_lsu) return RR_EN ? !m_last_lsu : 1'b1;
    return p_lsu;
  endfunction

  // Called in IDLE, #1 after a clock edge, with at least one request applied.
  task automatic run_txn(input int gnt_dly, input int rv_dly);
    bit          w;
    logic [31:0] ea, ed, rd;
    logic [3:0]  eb;
    bit          ewe;
    check_eq("idle_busy", busy_o, 0);
    w = model_pick_lsu();
    m_last_lsu = w;
    if (w) n_lsu_won++; else n_if_won++;
    ea  = w ? l_a : if_a;
    ewe = w ? l_w : 1'b0;
    eb  = w ? l_b : 4'hF;
    ed  = w ? l_d : 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i <= gnt_dly; i++) begin
      mem_gnt_i = (i == gnt_dly);
      #1;
      check_eq("req_mem_req", mem_req_o, 1);
      check_eq("req_busy", busy_o, 1);
      check_eq("req_addr", mem_addr_o, ea);
      check_eq("req_we", mem_we_o, ewe);
      check_eq("req_be", mem_be_o, eb);
      check_eq("req_wdata", mem_wdata_o, ed);
      check_eq("if_gnt", if_gnt_o, (i == gnt_dly) && !w);
      check_eq("lsu_gnt", lsu_gnt_o, (i == gnt_dly) && w);
      check_eq("req_if_rvalid", if_rvalid_o, 0);
      check_eq("req_lsu_rvalid", lsu_rvalid_o, 0);
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0;
    // The accepted requester may issue a fresh request straight away.
    if (w) begin
      p_lsu = 1'b0;
      if ($urandom_range(0, 1) == 1) new_lsu();
    end else begin
      p_if = 1'b0;
      if ($urandom_range(0, 1) == 1) new_if();
    end
    apply_reqs();
    for (int i = 0; i <= rv_dly; i++) begin
      rd           = $urandom;
      mem_rvalid_i = (i == rv_dly);
      mem_rdata_i  = rd;
      #1;
      check_eq("resp_mem_req", mem_req_o, 0);
      check_eq("resp_busy", busy_o, 1);
      check_eq("resp_if_gnt", if_gnt_o, 0);
      check_eq("resp_lsu_gnt", lsu_gnt_o, 0);
      check_eq("if_rvalid", if_rvalid_o, (i == rv_dly) && !w);
      check_eq("lsu_rvalid", lsu_rvalid_o, (i == rv_dly) && w);
      check_eq("if_rdata", if_rdata_o, rd);
      check_eq("lsu_rdata", lsu_rdata_o, rd);
      @(posedge clk); #1;
    end
    mem_rvalid_i = 1'b0;
  endtask

  // One IDLE cycle with no requests and a spurious memory response.
  task automatic idle_cycle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    #1;
    check_eq("idle_if_rvalid", if_rvalid_o, 0);
    check_eq("idle_lsu_rvalid", lsu_rvalid_o, 0);
    check_eq("idle_mem_req", mem_req_o, 0);
    check_eq("idle_busy2", busy_o, 0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    check_eq("idle_stays", busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_if_gnt"}, if_gnt_o, 0);
    check_eq({tag, "_lsu_gnt"}, lsu_gnt_o, 0);
    check_eq({tag, "_if_rvalid"}, if_rvalid_o, 0);
    check_eq({tag, "_lsu_rvalid"}, lsu_rvalid_o, 0);
    check_eq({tag, "_mem_req"}, mem_req_o, 0);
    check_eq({tag, "_mem_we"}, mem_we_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_addr"}, mem_addr_o, 0);
    check_eq({tag, "_wdata"}, mem_wdata_o, 0);
    check_eq({tag, "_be"}, mem_be_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    p_if = 1'b0; p_lsu = 1'b0;
    if_a = '0; l_a = '0; l_d = '0; l_w = 1'b0; l_b = '0;
    apply_reqs();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    n_if_won = 0; n_lsu_won = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst");

    // Fetch only, immediate grant and response.
    p_if = 1'b1; if_a = 32'h100;
    apply_reqs();
    run_txn(0, 0);

    // Store with a grant stalled three cycles.
    p_if = 1'b0; p_lsu = 1'b1;
    l_a = 32'h2004; l_w = 1'b1; l_b = 4'b0011; l_d = 32'hDEAD_BEEF;
    apply_reqs();
    run_txn(3, 0);

    // Four back-to-back ties.
    for (int k = 0; k < 4; k++) begin
      if (!p_if) new_if();
      if (!p_lsu) new_lsu();
      apply_reqs();
      run_txn(0, 0);
    end

    // Stalled response with a pending LSU request.
    if (!p_lsu) new_lsu();
    apply_reqs();
    run_txn(0, 5);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      if (!p_if && !p_lsu) begin
        idle_cycle();
        if ($urandom_range(0, 1) == 1) new_if();
        if ($urandom_range(0, 1) == 1) new_lsu();
        if (!p_if && !p_lsu) new_lsu();
        apply_reqs();
      end
      run_txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
    end

    // Reset in the middle of RESP, then a late response.
    p_if = 1'b0; new_lsu();
    apply_reqs();
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    p_lsu = 1'b0;
    apply_reqs();
    check_eq("mid_resp_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last_lsu = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    check_reset_outputs("late_rv");
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    check_eq("late_rv_idle", busy_o, 0);

    // First tie after reset exercises the reset value of the last-owner state.
    new_if(); new_lsu();
    apply_reqs();
    run_txn(1, 1);

    check_eq("both_ports_served", (n_if_won > 0) && (n_lsu_won > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
